// File: rtl/counter_arbiter_if.sv
// Request/grant bundle between requesting blocks and the shared counter arbiter.
// The master side drives requests, burst lengths and abort; the slave side returns grants and the count.
interface counter_arbiter_if #(
  parameter int N = 4,
  parameter int W = 3
);
  logic [N-1:0]   REQ;
  logic [N*W-1:0] LEN;
  logic           CLR;
  logic [N-1:0]   GNT;
  logic [N-1:0]   DONE;
  logic [W-1:0]   Q;
  logic           BUSY;

  modport master (
    output REQ, LEN, CLR,
    input  GNT, DONE, Q, BUSY
  );

  modport slave (
    input  REQ, LEN, CLR,
    output GNT, DONE, Q, BUSY
  );
endinterface

// File: rtl/counter_arbiter.sv
// One W-bit up-counter shared among N requesters; one burst at a time, granted round-robin.
// Define CNT_ARB_FIXED_PRIO_EN for fixed priority (lowest REQ index wins, pointer held at 0).
module counter_arbiter #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic             CK,
  input  logic             R,
  counter_arbiter_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  len_q, len_d;
  logic [IW-1:0] win_q, win_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] pick_w;
  logic [IW-1:0] ptr_next;

  // First set request bit at or after the start index, wrapping modulo N.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] req, input logic [IW-1:0] start);
    logic [IW-1:0] w;
    logic          found;
    int            j;
    w     = start;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && req[j]) begin
        w     = IW'(j);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    return IW'((int'(v) + 1) % N);
  endfunction

`ifdef CNT_ARB_FIXED_PRIO_EN
  assign pick_w   = pick(bus.REQ, '0);
  assign ptr_next = '0;
`else
  assign pick_w   = pick(bus.REQ, ptr_q);
  assign ptr_next = inc_mod(win_q);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        // CLR has no meaning here; arbitration proceeds regardless.
        if (bus.REQ != '0) begin
          win_d          = pick_w;
          gnt_d          = '0;
          gnt_d[pick_w]  = 1'b1;
          len_d          = bus.LEN[pick_w*W +: W];
          cnt_d          = '0;
          busy_d         = 1'b1;
          state_d        = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.CLR) begin
          gnt_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end else if (cnt_q != len_q) begin
          cnt_d = cnt_q + W'(1);
        end else begin
          done_d  = gnt_q;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        // Abort and normal completion land in the same place from here.
        gnt_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge R) begin
    if (!R) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.DONE = done_q;
  assign bus.Q    = cnt_q;
  assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: stimulus queues per-cycle expected outputs, a monitor pops them.
module tb_counter_arbiter;
  localparam int N = 4;
  localparam int W = 3;

  logic CK = 1'b0;
  logic R  = 1'b0;
  always #5 CK = ~CK;

  counter_arbiter_if #(.N(N), .W(W)) bus();
  counter_arbiter #(.N(N), .W(W)) dut (.CK(CK), .R(R), .bus(bus));

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic [W-1:0] q;
    logic         busy;
  } rec_t;

  rec_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RUN cycles with Q=0..upto for requester w.
  task automatic push_run(input int w, input int upto);
    rec_t r;
    for (int k = 0; k <= upto; k++) begin
      r      = '0;
      r.gnt[w] = 1'b1;
      r.q    = W'(k);
      r.busy = 1'b1;
      exp_q.push_back(r);
    end
  endtask

  task automatic push_burst(input int w, input int len);
    rec_t r;
    push_run(w, len);
    r         = '0;
    r.gnt[w]  = 1'b1;
    r.done[w] = 1'b1;
    r.q       = W'(len);
    r.busy    = 1'b1;
    exp_q.push_back(r);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CK);
      if (bus.BUSY === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: BUSY never reached %b within %0d cycles", name, lvl, budget);
    end
  endtask

  task automatic wait_q(input int qv, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CK);
      if (bus.BUSY === 1'b1 && bus.Q === W'(qv)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: Q never reached %0d within %0d cycles", name, qv, budget);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_gnt"},  32'(bus.GNT),  32'h0);
    chk({name, "_q"},    32'(bus.Q),    32'h0);
    chk({name, "_busy"}, 32'(bus.BUSY), 32'h0);
    chk({name, "_done"}, 32'(bus.DONE), 32'h0);
  endtask

  // Monitor: any cycle with activity on the outputs must match the next queued record.
  always @(negedge CK) begin
    rec_t act;
    rec_t e;
    if (R && (bus.BUSY || bus.GNT != '0 || bus.DONE != '0)) begin
      act.gnt  = bus.GNT;
      act.done = bus.DONE;
      act.q    = bus.Q;
      act.busy = bus.BUSY;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got gnt=%b done=%b q=%0d busy=%b, expected no activity",
                 act.gnt, act.done, act.q, act.busy);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL out_cycle: got gnt=%b done=%b q=%0d busy=%b, expected gnt=%b done=%b q=%0d busy=%b",
                   act.gnt, act.done, act.q, act.busy, e.gnt, e.done, e.q, e.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.REQ = '0;
    bus.LEN = '0;
    bus.CLR = 1'b0;
    R       = 1'b0;

    // Reset held with all requests asserted.
    bus.REQ = 4'b1111;
    repeat (4) begin
      @(negedge CK);
      chk_idle_outputs("reset");
    end
    bus.REQ = '0;
    @(posedge CK);
    #2 R = 1'b1;

    // All requesters, zero-length bursts: rotation with a one-cycle gap.
`ifdef CNT_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 5; k++) push_burst(0, 0);
`else
    push_burst(0, 0);
    push_burst(1, 0);
    push_burst(2, 0);
    push_burst(3, 0);
    push_burst(0, 0);
`endif
    bus.LEN = '0;
    bus.REQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        wait_busy(1'b1, 10, "rr_start");
      end else begin
        @(negedge CK);
        chk("rr_gap_regrant", 32'(bus.BUSY), 32'h1);
      end
      if (k == 4) bus.REQ = '0;
      wait_busy(1'b0, 10, "rr_end");
    end

    // Single requester 0, LEN0=3.
    push_burst(0, 3);
    bus.LEN = 12'd3;
    bus.REQ = 4'b0001;
    wait_busy(1'b1, 10, "b0_start");
    bus.REQ = '0;
    wait_busy(1'b0, 20, "b0_end");
    chk("b0_gnt_cleared", 32'(bus.GNT), 32'h0);

    // Max length on requester 2; LEN change mid-burst must be ignored.
    push_burst(2, 7);
    bus.LEN = 12'd7 << 6;
    bus.REQ = 4'b0100;
    wait_busy(1'b1, 10, "b2_start");
    bus.REQ = '0;
    bus.LEN = 12'd0;
    wait_busy(1'b0, 30, "b2_end");

    // Abort requester 1 at Q=2, then the pointer moves on.
    push_run(1, 2);
`ifdef CNT_ARB_FIXED_PRIO_EN
    push_burst(1, 5);
`else
    push_burst(2, 2);
`endif
    bus.LEN = (12'd5 << 3) | (12'd2 << 6);
    bus.REQ = 4'b0110;
    wait_busy(1'b1, 10, "clr_start");
    wait_q(2, 10, "clr_reach_q2");
    bus.CLR = 1'b1;
    @(negedge CK);
    bus.CLR = 1'b0;
    chk_idle_outputs("clr_abort");
    wait_busy(1'b1, 10, "after_clr_start");
    bus.REQ = '0;
    wait_busy(1'b0, 20, "after_clr_end");

    // Asynchronous reset in the middle of a LEN=6 burst.
    push_run(0, 4);
    bus.LEN = 12'd6;
    bus.REQ = 4'b0001;
    wait_busy(1'b1, 10, "rst_burst_start");
    bus.REQ = '0;
    wait_q(4, 10, "rst_reach_q4");
    #2 R = 1'b0;
    #1 chk_idle_outputs("async_rst");
    @(negedge CK);
    chk_idle_outputs("async_rst_hold");
    @(posedge CK);
    #2 R = 1'b1;
    push_burst(3, 1);
    bus.LEN = 12'd1 << 9;
    bus.REQ = 4'b1000;
    wait_busy(1'b1, 10, "post_rst_start");
    bus.REQ = '0;
    wait_busy(1'b0, 20, "post_rst_end");

    repeat (3) @(negedge CK);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
